mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter TIMEOUT, default 16, max cycles in REQ awaiting mem_ack before error; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  instruction valid; sampled only in IDLE.
REQ-006 opcode  input  7  RISC-V major opcode.
REQ-007 funct3  input  3  [1:0] access size (0 B, 1 H, 2 W, 3 D); [2] unsigned load.
REQ-008 addr  input  XLEN  effective byte address.
REQ-009 wdata  input  XLEN  store data, LSB-aligned.
REQ-010 busy_o  output  1  high whenever state is not IDLE; pipeline stall.
REQ-011 mem_req, mem_we  output  1 each  bus request and write strobe.
REQ-012 mem_addr  output  XLEN  word-aligned address (low log2(XLEN/8) bits zero).
REQ-013 mem_wdata  output  XLEN  store data replicated/shifted into byte lanes.
REQ-014 mem_be  output  XLEN/8  byte enables.
REQ-015 mem_ack  input  1  bus completion; mem_rdata input XLEN read data.
REQ-016 rdata_o  output  XLEN  extended load result; rd_we_o output 1 load writeback pulse.
REQ-017 done_o, err_o  output  1 each  completion / error one-cycle pulses.

Function
REQ-018 States: IDLE, REQ, DONE, ERR.
REQ-019 IDLE: valid_i with opcode 0000011 (LOAD) or 0100011 (STORE) latches opcode, funct3, addr, wdata and moves to REQ; any other opcode is ignored, outputs unchanged.
REQ-020 Illegal access (funct3[1:0]=3 when XLEN=32; STORE with funct3[2]=1) moves IDLE->ERR with no bus request.
REQ-021 mem_be = size mask (1/3/F/FF) shifted left by addr offset; mem_wdata = wdata shifted left by 8*offset.
REQ-022 REQ: mem_req=1, mem_we=1 for STORE; held stable until mem_ack sampled high, then DONE.
REQ-023 Timeout counter clears on REQ entry, increments each REQ cycle without ack; reaching TIMEOUT moves to ERR, mem_req drops next cycle.
REQ-024 On ack for LOAD: capture mem_rdata >> 8*offset, truncate to size, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) into rdata_o.
REQ-025 DONE: done_o=1 one cycle; rd_we_o=1 for LOAD only; then IDLE. ERR: err_o=1 one cycle, then IDLE.
REQ-026 Latency: valid_i at cycle N, ack at N+1 -> done_o at N+2; busy_o high cycles N+1..N+2.
REQ-027 mem_ack in IDLE/DONE/ERR ignored; mem_ack and timeout in same cycle -> ack wins.
REQ-028 rdata_o holds last load value until next load completes.

Reset
REQ-029 rst returns to IDLE from any state at next edge; all outputs 0, counter 0, rdata_o 0; in-flight access abandoned without done_o/err_o.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN: defined -> access whose addr is not size-aligned goes IDLE->ERR, no bus request; undefined -> misaligned low bits beyond size alignment are cleared and access proceeds normally.

Verification
REQ-031 XLEN=32, LW addr 0x100, ack at first REQ cycle, mem_rdata 0xDEADBEEF -> done_o and rd_we_o at N+2, rdata_o 0xDEADBEEF.
REQ-032 LB addr 0x103, mem_rdata 0x80000000 -> mem_be 4'b1000, rdata_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x102, wdata 0x1234 -> mem_we=1, mem_be 4'b1100, mem_wdata 0x12340000, rd_we_o stays 0.
REQ-034 TIMEOUT=4, LW, no ack -> mem_req high 4 cycles, err_o pulse, busy_o low after.
REQ-035 LW addr 0x101: with MISALIGN_TRAP_EN err_o, no mem_req; without, mem_addr 0x100, mem_be 4'b1111.
REQ-036 rst asserted in REQ -> next cycle IDLE, mem_req 0, no done_o/err_o; opcode 0110011 valid -> no activity.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: decodes RISC-V LOAD/STORE, drives one bus access, extends load data.
// Optional MISALIGN_TRAP_EN: misaligned accesses go to ERR instead of being force-aligned.
module mem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   rdata_o,
  output logic              rd_we_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            is_load_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;

  logic [OFFW-1:0] size_m;
  logic [OFFW-1:0] off_al;
  logic [NB-1:0]   be_base;
  logic            is_mem_op;
  logic            illegal;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

  always_comb begin
    size_m  = '0;
    be_base = '0;
    case (funct3[1:0])
      2'd0: begin size_m = OFFW'(0); be_base = NB'(1);     end
      2'd1: begin size_m = OFFW'(1); be_base = NB'(3);     end
      2'd2: begin size_m = OFFW'(3); be_base = NB'(8'h0F); end
      default: begin size_m = OFFW'(7); be_base = NB'(8'hFF); end
    endcase
  end

  // Low address bits beyond the access size are dropped so the lane shift stays size-aligned.
  assign off_al    = addr[OFFW-1:0] & ~size_m;
  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);

  always_comb begin
    illegal = ((funct3[1:0] == 2'd3) && (XLEN == 32)) ||
              ((opcode == OP_STORE) && funct3[2]);
`ifdef MISALIGN_TRAP_EN
    if ((addr[OFFW-1:0] & size_m) != '0) illegal = 1'b1;
`endif
  end

  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    case (size_q)
      2'd0: ext = {{(XLEN-8){~uns_q & shifted[7]}},   shifted[7:0]};
      2'd1: ext = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2: ext = {{(XLEN-32){~uns_q & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_load_q <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      busy_o    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rdata_o   <= '0;
      rd_we_o   <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rd_we_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && is_mem_op) begin
            is_load_q <= (opcode == OP_LOAD);
            uns_q     <= funct3[2];
            size_q    <= funct3[1:0];
            off_q     <= off_al;
            busy_o    <= 1'b1;
            if (illegal) begin
              state <= ERR;
              err_o <= 1'b1;
            end else begin
              state     <= REQ;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OP_STORE);
              mem_addr  <= {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_be    <= be_base << off_al;
              mem_wdata <= wdata << {off_al, 3'b000};
            end
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the final allowed cycle still completes.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done_o  <= 1'b1;
            rd_we_o <= is_load_q;
            if (is_load_q) rdata_o <= ext;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state   <= ERR;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_o   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (XLEN=32, TIMEOUT=4); honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_ctrl;

  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            busy_o;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] rdata_o;
  logic            rd_we_o;
  logic            done_o;
  logic            err_o;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy_o(busy_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rdata_o(rdata_o), .rd_we_o(rd_we_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; opcode = op; funct3 = f3; addr = a; wdata = wd;
    tick();
    valid_i = 1'b0;
  endtask

  // Full access with ack after ack_wait extra REQ cycles; checks request and completion.
  task automatic access(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_wait, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    logic is_st;
    is_st = (op == OP_STORE);
    issue(op, f3, a, wd);
    chk({tag, ".req"},  mem_req, 1);
    chk({tag, ".we"},   mem_we, is_st);
    chk({tag, ".addr"}, mem_addr, exp_addr);
    chk({tag, ".be"},   mem_be, exp_be);
    chk({tag, ".busy"}, busy_o, 1);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk({tag, ".req_hold"}, mem_req, 1);
      chk({tag, ".addr_hold"}, mem_addr, exp_addr);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    chk({tag, ".done"},  done_o, 1);
    chk({tag, ".rd_we"}, rd_we_o, !is_st);
    chk({tag, ".rdata"}, rdata_o, exp_rdata);
    chk({tag, ".busy2"}, busy_o, 1);
    chk({tag, ".req_off"}, mem_req, 0);
    tick();
    chk({tag, ".idle"},  busy_o, 0);
    chk({tag, ".done_pulse"}, done_o, 0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; opcode = '0; funct3 = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", busy_o, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.rdata", rdata_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.be", mem_be, 0);

    access("lw",  OP_LOAD, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 32'h100, 4'hF, 32'hDEAD_BEEF);
    access("lb",  OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 32'h100, 4'h8, 32'hFFFF_FF80);
    access("lbu", OP_LOAD, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 0, 32'h100, 4'h8, 32'h0000_0080);

    // Store leaves the last load result untouched.
    issue(OP_STORE, 3'b001, 32'h102, 32'h1234);
    chk("sh.wdata", mem_wdata, 32'h1234_0000);
    chk("sh.be", mem_be, 4'hC);
    chk("sh.we", mem_we, 1);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("sh.done", done_o, 1);
    chk("sh.rd_we", rd_we_o, 0);
    chk("sh.rdata_hold", rdata_o, 32'h0000_0080);
    tick();
    chk("sh.idle", busy_o, 0);

    access("lh_wait", OP_LOAD, 3'b001, 32'h202, 32'h0, 32'h8001_0000, 2, 32'h200, 4'hC, 32'hFFFF_8001);
    access("sb", OP_STORE, 3'b000, 32'h301, 32'hAB, 32'h0, 0, 32'h300, 4'h2, 32'hFFFF_8001);

`ifdef MISALIGN_TRAP_EN
    issue(OP_LOAD, 3'b010, 32'h101, 32'h0);
    chk("mis.err", err_o, 1);
    chk("mis.req", mem_req, 0);
    tick();
    chk("mis.idle", busy_o, 0);
`else
    access("mis", OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 32'h100, 4'hF, 32'h1122_3344);
`endif

    // Timeout: four REQ cycles without ack.
    issue(OP_LOAD, 3'b010, 32'h400, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to.req", mem_req, 1);
      chk("to.err_early", err_o, 0);
      tick();
    end
    chk("to.err", err_o, 1);
    chk("to.req_drop", mem_req, 0);
    chk("to.busy", busy_o, 1);
    tick();
    chk("to.idle", busy_o, 0);
    chk("to.err_pulse", err_o, 0);

    // Ack on the last allowed cycle wins over timeout.
    access("ack_vs_to", OP_LOAD, 3'b010, 32'h500, 32'h0, 32'hCAFE_F00D, 3, 32'h500, 4'hF, 32'hCAFE_F00D);

    issue(OP_STORE, 3'b100, 32'h600, 32'h1);
    chk("ill_st.err", err_o, 1);
    chk("ill_st.req", mem_req, 0);
    tick();
    issue(OP_LOAD, 3'b011, 32'h600, 32'h0);
    chk("ill_ld.err", err_o, 1);
    chk("ill_ld.req", mem_req, 0);
    tick();
    chk("ill_ld.idle", busy_o, 0);

    // Reset while in REQ abandons the access silently.
    issue(OP_LOAD, 3'b010, 32'h700, 32'h0);
    chk("rstreq.req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstreq.req0", mem_req, 0);
    chk("rstreq.busy", busy_o, 0);
    chk("rstreq.rdata", rdata_o, 0);
    chk("rstreq.done", done_o, 0);
    chk("rstreq.err", err_o, 0);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("rstreq.done_late", done_o, 0);
    chk("rstreq.err_late", err_o, 0);

    // Non-memory opcode is ignored.
    issue(7'b0110011, 3'b010, 32'h800, 32'h0);
    chk("alu.busy", busy_o, 0);
    chk("alu.req", mem_req, 0);
    chk("alu.addr", mem_addr, 0);
    tick();
    chk("alu.err", err_o, 0);
    chk("alu.done", done_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
